// File: rtl/traffic_pkg.sv
// Shared types for the highway/farm-road light controller: light encoding and
// the state enums of the two handshaking FSMs.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        HW_GREEN  = 2'b00,
        HW_YELLOW = 2'b01,
        HW_IDLE   = 2'b10
    } hw_state_t;

    typedef enum logic [1:0] {
        FW_IDLE   = 2'b00,
        FW_GREEN  = 2'b01,
        FW_YELLOW = 2'b10
    } fw_state_t;

endpackage

// File: rtl/tl_timer.sv
// Shared interval timer: saturating up-counter with clear, plus short/long
// threshold compares on the registered count.
module tl_timer #(
    parameter int SHORT_CYCLES = 3,
    parameter int LONG_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic short_timeout,
    output logic long_timeout
);
    localparam int CW = $clog2(LONG_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (count != CW'(LONG_CYCLES))
            count <= count + CW'(1);
    end

    assign short_timeout = (count >= CW'(SHORT_CYCLES));
    assign long_timeout  = (count >= CW'(LONG_CYCLES));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Intersection controller: highway and farm-road FSMs hand the right of way
// to each other through one-cycle invoke pulses, sharing a single timer.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int SHORT_CYCLES = 3,
    parameter int LONG_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_on_fw,
    output logic [1:0] hw_light,
    output logic [1:0] fw_light,
    output logic       short_timeout,
    output logic       long_timeout
);
    hw_state_t hw_state, hw_next;
    fw_state_t fw_state, fw_next;
    logic      invk_hw, invk_fw;
    logic      timer_hw_reset, timer_fw_reset;

    tl_timer #(
        .SHORT_CYCLES(SHORT_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clr          (timer_hw_reset | timer_fw_reset),
        .short_timeout(short_timeout),
        .long_timeout (long_timeout)
    );

    // Handover pulses derived straight from state so neither FSM depends on
    // the other's next-state logic (no combinational loop between them).
    assign timer_hw_reset = ((hw_state == HW_GREEN) && long_timeout && car_on_fw) ||
                            ((hw_state == HW_YELLOW) && short_timeout);
    assign invk_fw        = (hw_state == HW_YELLOW) && short_timeout;
    assign timer_fw_reset = ((fw_state == FW_GREEN) && (!car_on_fw || long_timeout)) ||
                            ((fw_state == FW_YELLOW) && short_timeout);
    assign invk_hw        = (fw_state == FW_YELLOW) && short_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            hw_state <= HW_GREEN;
            fw_state <= FW_IDLE;
        end else begin
            hw_state <= hw_next;
            fw_state <= fw_next;
        end
    end

    always_comb begin
        hw_next = hw_state;
        unique case (hw_state)
            HW_GREEN:  if (long_timeout && car_on_fw) hw_next = HW_YELLOW;
            HW_YELLOW: if (short_timeout)             hw_next = HW_IDLE;
            HW_IDLE:   if (invk_hw)                   hw_next = HW_GREEN;
            default:                                  hw_next = HW_GREEN;
        endcase
    end

    always_comb begin
        fw_next = fw_state;
        unique case (fw_state)
            FW_IDLE:   if (invk_fw)                     fw_next = FW_GREEN;
            FW_GREEN:  if (!car_on_fw || long_timeout)  fw_next = FW_YELLOW;
            FW_YELLOW: if (short_timeout)               fw_next = FW_IDLE;
            default:                                    fw_next = FW_IDLE;
        endcase
    end

    always_comb begin
        hw_light = RED;
        fw_light = RED;
        case (hw_state)
            HW_GREEN:  hw_light = GREEN;
            HW_YELLOW: hw_light = YELLOW;
            default:   hw_light = RED;
        endcase
        case (fw_state)
            FW_GREEN:  fw_light = GREEN;
            FW_YELLOW: fw_light = YELLOW;
            default:   fw_light = RED;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: driver steps a phase/age reference model and queues the
// expected outputs; a monitor pops and compares after every clock edge.
module tb_traffic_light_ctrl;
    localparam int SHORT = 3;
    localparam int LONG  = 10;

    logic       clk, reset, car_on_fw;
    logic [1:0] hw_light, fw_light;
    logic       short_timeout, long_timeout;

    traffic_light_ctrl #(.SHORT_CYCLES(SHORT), .LONG_CYCLES(LONG)) dut (
        .clk          (clk),
        .reset        (reset),
        .car_on_fw    (car_on_fw),
        .hw_light     (hw_light),
        .fw_light     (fw_light),
        .short_timeout(short_timeout),
        .long_timeout (long_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] hw;
        logic [1:0] fw;
        logic       st;
        logic       lt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Phases in order: 0 hw green, 1 hw yellow, 2 fw green, 3 fw yellow.
    int phase = 0;
    int age   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit c);
        bit adv;
        if (r) begin
            phase = 0;
            age   = 0;
        end else begin
            case (phase)
                0:       adv = (age >= LONG) && c;
                1:       adv = (age >= SHORT);
                2:       adv = !c || (age >= LONG);
                default: adv = (age >= SHORT);
            endcase
            if (adv) begin
                phase = (phase + 1) % 4;
                age   = 0;
            end else if (age < LONG) begin
                age++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.hw = (phase == 0) ? 2'b10 : (phase == 1) ? 2'b01 : 2'b00;
        e.fw = (phase == 2) ? 2'b10 : (phase == 3) ? 2'b01 : 2'b00;
        e.st = (age >= SHORT);
        e.lt = (age >= LONG);
        return e;
    endfunction

    task automatic cycle(input bit r, input bit c);
        @(negedge clk);
        reset     = r;
        car_on_fw = c;
        model_step(r, c);
        exp_q.push_back(model_out());
    endtask

    task automatic run_until_phase(input int p, input bit c);
        int n = 0;
        while (phase != p && n < 100) begin
            cycle(1'b0, c);
            n++;
        end
        chk("reach_phase", phase, p);
    endtask

    // Monitor: every expectation queued before an edge is checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hw_light", hw_light, e.hw);
                chk("fw_light", fw_light, e.fw);
                chk("short_timeout", short_timeout, e.st);
                chk("long_timeout", long_timeout, e.lt);
                chk("one_non_red", int'(hw_light != 2'b00 && fw_light != 2'b00), 0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        car_on_fw = 1'b0;

        // Reset, then idle highway with no farm traffic.
        repeat (2) cycle(1'b1, 1'b0);
        repeat (30) cycle(1'b0, 1'b0);

        // Constant farm demand: two full rotations.
        repeat (60) cycle(1'b0, 1'b1);

        // Farm car leaves on the 3rd cycle of farm green.
        run_until_phase(2, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0);

        // Car appears 5 cycles after reset.
        cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b1);

        // Car vanishes during highway yellow.
        run_until_phase(1, 1'b1);
        repeat (12) cycle(1'b0, 1'b0);

        // Reset in the middle of farm yellow.
        run_until_phase(3, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
